// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared decode bit positions, resolver state encoding and defaults
package ctrl_pkg;
  localparam int SHADOW_DEFAULT = 3;
  localparam int D_BLT = 0;
  localparam int D_BNE = 1;
  localparam int D_BEX = 2;
  localparam int D_JAL = 3;
  localparam int D_J   = 4;
  localparam int D_JR  = 5;
  localparam int D_W   = 6;
  typedef enum logic {ST_RESOLVE = 1'b0, ST_SHADOW = 1'b1} state_e;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational not-equal, signed less-than and rstatus non-zero evaluation
module branch_cond #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] rd_i,
  input  logic [PC_W-1:0] rs_i,
  input  logic [PC_W-1:0] rstatus_i,
  output logic            ne_o,
  output logic            lt_o,
  output logic            nz_o
);
  logic [PC_W:0] diff;
  // one extra sign bit keeps the difference exact, so overflow cannot flip lt
  assign diff = {rd_i[PC_W-1], rd_i} - {rs_i[PC_W-1], rs_i};
  assign ne_o = |(rd_i ^ rs_i);
  assign lt_o = diff[PC_W];
  assign nz_o = |rstatus_i;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch/jump resolution, PC redirect, wrong-path squash and statistics
module branch_resolver
  import ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int TGT_W  = 27,
  parameter int SHADOW = SHADOW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             valid_x,
  input  logic             is_bne,
  input  logic             is_blt,
  input  logic             is_j,
  input  logic             is_jal,
  input  logic             is_jr,
  input  logic             is_bex,
  input  logic [PC_W-1:0]  pc_x,
  input  logic [PC_W-1:0]  imm,
  input  logic [TGT_W-1:0] target,
  input  logic [PC_W-1:0]  rd_val,
  input  logic [PC_W-1:0]  rs_val,
  input  logic [PC_W-1:0]  rstatus_val,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             squash,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);
  state_e           state_q;
  logic [1:0]       sh_cnt_q;
  logic             redirect_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_count_q, branch_count_d, taken_count_q, taken_count_d;
  logic [D_W-1:0]   dec;
  logic             ne, lt, nz, resolve, cond, taken;
  logic [PC_W-1:0]  tgt;
  assign dec = {is_jr, is_j, is_jal, is_bex, is_bne, is_blt};
  branch_cond #(.PC_W(PC_W)) u_cond (
    .rd_i(rd_val), .rs_i(rs_val), .rstatus_i(rstatus_val),
    .ne_o(ne), .lt_o(lt), .nz_o(nz)
  );
  always_comb begin
    resolve = valid_x & ~stall & (state_q == ST_RESOLVE) & (|dec);
    cond = (dec[D_JR] | dec[D_J] | dec[D_JAL]) ? 1'b1 :
           dec[D_BEX] ? nz : dec[D_BNE] ? ne : lt;
    taken = resolve & cond;
    tgt = dec[D_JR] ? rd_val :
          (dec[D_J] | dec[D_JAL] | dec[D_BEX]) ? PC_W'(target) :
          pc_x + PC_W'(1) + imm;
    branch_count_d = branch_count_q + CNT_W'(resolve && branch_count_q != '1);
    taken_count_d = taken_count_q + CNT_W'(taken && taken_count_q != '1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RESOLVE;
      sh_cnt_q       <= '0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      redirect_q     <= taken;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
      if (taken) begin
        redirect_pc_q <= tgt;
        state_q       <= ST_SHADOW;
        sh_cnt_q      <= 2'(SHADOW - 1);
      end else if (state_q == ST_SHADOW && !stall) begin
        if (sh_cnt_q == 2'd0) state_q <= ST_RESOLVE;
        else sh_cnt_q <= sh_cnt_q - 2'd1;
      end
    end
  end
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign squash       = valid_x & ~reset & (state_q == ST_SHADOW);
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: scoreboard bench for branch_resolver redirects, squash window and saturating counters
module tb_branch_resolver;
  localparam int CW = 10;
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [5:0] JR = 6'b100000, J = 6'b010000, JAL = 6'b001000;
  localparam logic [5:0] BEX = 6'b000100, BNE = 6'b000010, BLT = 6'b000001;
  logic clock = 0, reset, stall, valid_x;
  logic is_bne, is_blt, is_j, is_jal, is_jr, is_bex;
  logic [31:0] pc_x, imm, rd_val, rs_val, rstatus_val, redirect_pc;
  logic [26:0] target;
  logic redirect, squash;
  logic [CW-1:0] branch_count, taken_count;
  logic [31:0] q[$];
  logic [CW-1:0] eb, et;
  int n_chk = 0, n_fail = 0;
  branch_resolver #(.CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .valid_x(valid_x),
    .is_bne(is_bne), .is_blt(is_blt), .is_j(is_j), .is_jal(is_jal), .is_jr(is_jr), .is_bex(is_bex),
    .pc_x(pc_x), .imm(imm), .target(target), .rd_val(rd_val), .rs_val(rs_val),
    .rstatus_val(rstatus_val), .redirect(redirect), .redirect_pc(redirect_pc), .squash(squash),
    .branch_count(branch_count), .taken_count(taken_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (redirect) begin
      if (q.size() == 0) check("redir_unexpected", 32'd1, 32'd0);
      else check("redir_pc", redirect_pc, q.pop_front());
    end
  end
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [5:0] d, input logic [31:0] rd, input logic [31:0] rs,
                       input logic [31:0] pc, input logic [31:0] im, input logic [26:0] t,
                       input logic [31:0] rst);
    valid_x = 1;
    {is_jr, is_j, is_jal, is_bex, is_bne, is_blt} = d;
    rd_val = rd; rs_val = rs; pc_x = pc; imm = im; target = t; rstatus_val = rst;
  endtask
  task automatic idle;
    valid_x = 0;
    {is_jr, is_j, is_jal, is_bex, is_bne, is_blt} = '0;
  endtask
  task automatic bump(input logic tk);
    eb = (eb == MAX) ? MAX : eb + 1'b1;
    if (tk) et = (et == MAX) ? MAX : et + 1'b1;
  endtask
  task automatic check_counts(input string tag);
    check({tag, "_bc"}, 32'(branch_count), 32'(eb));
    check({tag, "_tc"}, 32'(taken_count), 32'(et));
  endtask
  initial begin
    reset = 1; stall = 0; eb = 0; et = 0;
    idle;
    drive(6'b0, 0, 0, 0, 0, 0, 0);
    idle;
    step; step;
    reset = 0;
    check("rst_redirect", 32'(redirect), 0);
    check("rst_pc", redirect_pc, 0);
    check_counts("rst");
    valid_x = 1; #1;
    check("rst_squash", 32'(squash), 0);
    idle;
    drive(BNE, 5, 5, 100, 8, 0, 0); step; idle; bump(0);
    check("bne_nt_redir", 32'(redirect), 0);
    check_counts("bne_nt");
    drive(BNE, 5, 6, 100, 8, 0, 0); q.push_back(109); step; bump(1);
    idle; valid_x = 1; #1;
    for (int i = 0; i < 3; i++) begin
      check("bne_squash", 32'(squash), 1);
      step;
    end
    check("bne_unsquash", 32'(squash), 0);
    check_counts("bne_t");
    idle;
    drive(BLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'hFFFF_FFFF, 0, 0);
    q.push_back(32'h200); step; idle; bump(1); repeat (3) step;
    drive(BLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h200, 0, 0, 0); step; idle; bump(0);
    check("blt_nt_redir", 32'(redirect), 0);
    drive(BLT, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 32'h20, 0, 0);
    q.push_back(32'h11); step; idle; bump(1); repeat (3) step;
    check_counts("blt");
    drive(JR, 32'h123, 0, 0, 0, 0, 0); q.push_back(32'h123); step; bump(1);
    for (int i = 0; i < 3; i++) begin
      drive(BNE, 1, 2, 0, 0, 0, 0); #1;
      check("jr_shadow_squash", 32'(squash), 1);
      step;
    end
    idle;
    check_counts("jr");
    drive(J, 0, 0, 0, 0, 27'h40, 0); q.push_back(32'h40); step; bump(1);
    idle; valid_x = 1; #1;
    check("j_sq1", 32'(squash), 1);
    step; stall = 1; #1;
    check("j_sq2", 32'(squash), 1);
    check("j_pulse", 32'(redirect), 0);
    step; stall = 0; #1;
    check("j_sq3", 32'(squash), 1);
    step;
    check("j_sq4", 32'(squash), 1);
    step;
    check("j_sq5", 32'(squash), 0);
    idle;
    stall = 1; drive(BNE, 1, 2, 32'h10, 32'h10, 0, 0); step;
    check("stall_noredir", 32'(redirect), 0);
    check_counts("stall");
    stall = 0; q.push_back(32'h21); step; bump(1); idle; repeat (3) step;
    drive(JR | BNE, 32'h77, 32'h77, 0, 0, 27'h5, 0); q.push_back(32'h77); step; idle; bump(1); repeat (3) step;
    drive(BEX | BNE, 1, 2, 0, 0, 27'h5, 0); step; idle; bump(0);
    check("prio_bex_redir", 32'(redirect), 0);
    check_counts("prio");
    drive(JAL, 0, 0, 0, 0, 27'h55, 0); q.push_back(32'h55); step;
    idle; valid_x = 1; step; reset = 1; step; reset = 0; eb = 0; et = 0; #1;
    check("mid_rst_squash", 32'(squash), 0);
    check("mid_rst_redir", 32'(redirect), 0);
    check("mid_rst_pc", redirect_pc, 0);
    check_counts("mid_rst");
    drive(BEX, 0, 0, 0, 0, 27'h66, 1); q.push_back(32'h66); step; bump(1);
    check("bex_redir", 32'(redirect), 1);
    idle; repeat (3) step;
    reset = 1; drive(J, 0, 0, 0, 0, 27'h40, 0); step; reset = 0; idle; eb = 0; et = 0;
    check("rst_drop_redir", 32'(redirect), 0);
    check_counts("rst_drop");
    for (int i = 0; i < int'(MAX); i++) begin
      drive(J, 0, 0, 0, 0, 27'h40, 0); q.push_back(32'h40); step; idle; bump(1); repeat (3) step;
    end
    check_counts("presat");
    drive(J, 0, 0, 0, 0, 27'h40, 0); q.push_back(32'h40); step; idle; bump(1); repeat (3) step;
    check("sat_bc", 32'(branch_count), 32'(MAX));
    check("sat_tc", 32'(taken_count), 32'(MAX));
    drive(BNE, 3, 3, 0, 0, 0, 0); step; idle; bump(0);
    check("sat_bc_nt", 32'(branch_count), 32'(MAX));
    step; step;
    check("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
